// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset defaults, status bit layout,
// branch flag-select codes and the fetch FSM encoding.
package cpu_pkg;

  localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;
  localparam logic [7:0]  NOP_OPCODE_DEF   = 8'hEA;

  localparam int STATUS_N = 7;
  localparam int STATUS_V = 6;
  localparam int STATUS_Z = 1;
  localparam int STATUS_C = 0;

  typedef enum logic [1:0] {
    FLAG_N = 2'b00,
    FLAG_V = 2'b01,
    FLAG_C = 2'b10,
    FLAG_Z = 2'b11
  } flag_sel_e;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } fetch_state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/branch_condition.sv
// Combinational branch resolver: selects one status flag by branch_op[2:1]
// and compares it with the required value in branch_op[0].
module branch_condition
  import cpu_pkg::*;
(
  input  logic [7:0] i_status,
  input  logic [2:0] i_branch_op,
  output logic       o_taken
);

  logic w_flag;
  logic w_unused_flags;

  // Bits 5..2 of the status byte never drive a branch.
  assign w_unused_flags = ^i_status[5:2];

  always_comb begin
    w_flag = 1'b0;
    case (flag_sel_e'(i_branch_op[2:1]))
      FLAG_N:  w_flag = i_status[STATUS_N];
      FLAG_V:  w_flag = i_status[STATUS_V];
      FLAG_C:  w_flag = i_status[STATUS_C];
      FLAG_Z:  w_flag = i_status[STATUS_Z];
      default: w_flag = 1'b0;
    endcase
  end

  assign o_taken = (w_flag == i_branch_op[0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, runs the reset-vector fetch,
// captures opcode bytes and flushes the decoder on taken branches/jumps.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [7:0]  NOP_OPCODE   = NOP_OPCODE_DEF
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        increment,
  input  logic        lower_byte,
  input  logic        pc_data,
  input  logic [15:0] addr_in,
  input  logic        branch_uncon,
  input  logic        branch_con,
  input  logic [2:0]  branch_op,
  input  logic [7:0]  status,
  input  logic [7:0]  data_in,
  input  logic        mem_ready,
  output logic [15:0] address,
  output logic [15:0] pc,
  output logic [7:0]  instruction,
  output logic        instr_valid,
  output logic        flush,
  output logic        normal
);

  localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;

  fetch_state_e r_state;
  logic [15:0]  r_pc;
  logic [7:0]   r_staged_lo;
  logic [7:0]   r_instruction;
  logic         r_instr_valid;
  logic         r_flush;
  logic         r_normal;

  fetch_state_e w_state_next;
  logic [15:0]  w_pc_next;
  logic [7:0]   w_staged_lo_next;
  logic [7:0]   w_instruction_next;
  logic         w_instr_valid_next;
  logic         w_flush_next;
  logic         w_normal_next;
  logic         w_redirect;
  logic         w_taken;
  logic [15:0]  w_address;

  branch_condition u_branch_condition (
    .i_status    (status),
    .i_branch_op (branch_op),
    .o_taken     (w_taken)
  );

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state       <= VEC_LO;
      r_pc          <= RESET_VECTOR;
      r_staged_lo   <= 8'h00;
      r_instruction <= NOP_OPCODE;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_normal      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_staged_lo   <= w_staged_lo_next;
      r_instruction <= w_instruction_next;
      r_instr_valid <= w_instr_valid_next;
      r_flush       <= w_flush_next;
      r_normal      <= w_normal_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_staged_lo_next   = r_staged_lo;
    w_instruction_next = r_instruction;
    w_instr_valid_next = 1'b0;
    w_flush_next       = 1'b0;
    w_normal_next      = r_normal;
    w_redirect         = 1'b0;
    w_address          = RESET_VECTOR;

    case (r_state)
      VEC_LO: begin
        w_address = RESET_VECTOR;
        if (mem_ready) begin
          w_staged_lo_next = data_in;
          w_state_next     = VEC_HI;
        end
      end

      VEC_HI: begin
        w_address = VEC_HI_ADDR;
        if (mem_ready) begin
          w_pc_next     = {data_in, r_staged_lo};
          w_state_next  = RUN;
          w_normal_next = 1'b1;
        end
      end

      RUN: begin
        w_address = pc_data ? r_pc : addr_in;
        if (mem_ready) begin
          // Jump low phase stages the byte; the high phase redirects.
          if (branch_uncon && lower_byte) begin
            w_staged_lo_next = data_in;
            w_pc_next        = r_pc + {15'd0, increment};
          end else if (branch_uncon) begin
            w_pc_next  = {data_in, r_staged_lo};
            w_redirect = 1'b1;
          end else if (branch_con && w_taken) begin
            w_pc_next  = r_pc + 16'd1 + sext8(data_in);
            w_redirect = 1'b1;
          end else if (branch_con || increment) begin
            w_pc_next = r_pc + 16'd1;
          end

          w_flush_next = w_redirect;
          if (w_redirect) begin
            w_instruction_next = NOP_OPCODE;
          end else if (pc_data) begin
            w_instruction_next = data_in;
            w_instr_valid_next = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = VEC_LO;
      end
    endcase
  end

  assign address     = w_address;
  assign pc          = r_pc;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign flush       = r_flush;
  assign normal      = r_normal;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected observations,
// a separate monitor pops and compares them on the falling clock edge.
module tb_fetch_unit;

  logic        clk_1;
  logic        rst;
  logic        increment;
  logic        lower_byte;
  logic        pc_data;
  logic [15:0] addr_in;
  logic        branch_uncon;
  logic        branch_con;
  logic [2:0]  branch_op;
  logic [7:0]  status;
  logic [7:0]  data_in;
  logic        mem_ready;
  logic [15:0] address;
  logic [15:0] pc;
  logic [7:0]  instruction;
  logic        instr_valid;
  logic        flush;
  logic        normal;

  typedef struct {
    int          id;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [7:0]  instr;
    logic        iv;
    logic        fl;
    logic        nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  fetch_unit dut (
    .clk_1        (clk_1),
    .rst          (rst),
    .increment    (increment),
    .lower_byte   (lower_byte),
    .pc_data      (pc_data),
    .addr_in      (addr_in),
    .branch_uncon (branch_uncon),
    .branch_con   (branch_con),
    .branch_op    (branch_op),
    .status       (status),
    .data_in      (data_in),
    .mem_ready    (mem_ready),
    .address      (address),
    .pc           (pc),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .flush        (flush),
    .normal       (normal)
  );

  initial begin
    clk_1 = 1'b0;
    forever #5 clk_1 = ~clk_1;
  end

  task automatic chk(input int id, input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL txn %0d %s: got %h expected %h", id, name, got, want);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %0d: addr=%h pc=%h instr=%h iv=%b flush=%b normal=%b", e.id,
                 address, pc, instruction, instr_valid, flush, normal);
        chk(e.id, "address",     address,              e.addr);
        chk(e.id, "pc",          pc,                   e.pc);
        chk(e.id, "instruction", {8'h00, instruction}, {8'h00, e.instr});
        chk(e.id, "instr_valid", {15'd0, instr_valid}, {15'd0, e.iv});
        chk(e.id, "flush",       {15'd0, flush},       {15'd0, e.fl});
        chk(e.id, "normal",      {15'd0, normal},      {15'd0, e.nm});
      end
    end
  end

  // Drives one cycle of inputs (just after the rising edge), records what
  // must be visible before the next rising edge, then advances one cycle.
  task automatic cyc(input logic r, input logic rdy, input logic [7:0] d,
                     input logic pcd, input logic inc, input logic lb,
                     input logic bu, input logic bc, input logic [2:0] bop,
                     input logic [7:0] st, input logic [15:0] ain,
                     input logic [15:0] ea, input logic [15:0] epc,
                     input logic [7:0] ei, input logic eiv, input logic efl,
                     input logic enm);
    exp_t e;
    rst          = r;
    mem_ready    = rdy;
    data_in      = d;
    pc_data      = pcd;
    increment    = inc;
    lower_byte   = lb;
    branch_uncon = bu;
    branch_con   = bc;
    branch_op    = bop;
    status       = st;
    addr_in      = ain;
    txn_id++;
    e.id = txn_id; e.addr = ea; e.pc = epc; e.instr = ei;
    e.iv = eiv; e.fl = efl; e.nm = enm;
    exp_q.push_back(e);
    @(posedge clk_1);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; data_in = 8'h00; pc_data = 1'b0;
    increment = 1'b0; lower_byte = 1'b0; branch_uncon = 1'b0;
    branch_con = 1'b0; branch_op = 3'b000; status = 8'h00; addr_in = 16'h0000;
    #2 rst = 1'b0;
    @(posedge clk_1);
    #1;
    //  r  rdy d      pcd inc lb bu bc bop     st     ain       addr      pc        instr iv fl nm
    // Reset vector fetch
    cyc(0, 1, 8'h34, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFC, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 1, 8'h34, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFC, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 1, 8'h12, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFD, 16'hFFFC, 8'hEA, 0, 0, 0);
    // Sequential fetch with 3-cycle stall
    cyc(1, 1, 8'hA9, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1234, 16'h1234, 8'hEA, 0, 0, 1);
    cyc(1, 1, 8'h05, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1235, 16'h1235, 8'hA9, 1, 0, 1);
    cyc(1, 0, 8'hFF, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1236, 16'h1236, 8'h05, 1, 0, 1);
    cyc(1, 0, 8'hFF, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1236, 16'h1236, 8'h05, 0, 0, 1);
    cyc(1, 0, 8'hFF, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1236, 16'h1236, 8'h05, 0, 0, 1);
    cyc(1, 1, 8'hEA, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h1236, 16'h1236, 8'h05, 0, 0, 1);
    // Operand read from addr_in: no capture, PC holds
    cyc(1, 1, 8'h77, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0200, 16'h0200, 16'h1237, 8'hEA, 1, 0, 1);
    // Jump to 0005
    cyc(1, 1, 8'h05, 1, 1, 1, 1, 0, 3'b000, 8'h00, 16'h0000, 16'h1237, 16'h1237, 8'hEA, 0, 0, 1);
    cyc(1, 1, 8'h00, 1, 0, 0, 1, 0, 3'b000, 8'h00, 16'h0000, 16'h1238, 16'h1238, 8'h05, 1, 0, 1);
    // BEQ taken backward from 0005 (Z=1, offset F0) -> FFF6
    cyc(1, 1, 8'hF0, 1, 0, 0, 0, 1, 3'b111, 8'h02, 16'h0000, 16'h0005, 16'h0005, 8'hEA, 0, 1, 1);
    // BEQ not taken (Z=0) -> PC+1
    cyc(1, 1, 8'hF0, 1, 0, 0, 0, 1, 3'b111, 8'h00, 16'h0000, 16'hFFF6, 16'hFFF6, 8'hEA, 0, 1, 1);
    // BCC with C=1: not taken
    cyc(1, 1, 8'h10, 1, 0, 0, 0, 1, 3'b100, 8'h01, 16'h0000, 16'hFFF7, 16'hFFF7, 8'hF0, 1, 0, 1);
    // BMI with N=1: taken forward, FFF8+1+6 = FFFF
    cyc(1, 1, 8'h06, 1, 0, 0, 0, 1, 3'b001, 8'h80, 16'h0000, 16'hFFF8, 16'hFFF8, 8'h10, 1, 0, 1);
    // Increment wraps FFFF -> 0000
    cyc(1, 1, 8'hAA, 1, 1, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF, 8'hEA, 0, 1, 1);
    // Jump to C000; low phase also asserts a taken branch_con, which is ignored
    cyc(1, 1, 8'h00, 1, 1, 1, 1, 1, 3'b111, 8'h02, 16'h0000, 16'h0000, 16'h0000, 8'hAA, 1, 0, 1);
    cyc(1, 1, 8'hC0, 1, 0, 0, 1, 0, 3'b000, 8'h00, 16'h0000, 16'h0001, 16'h0001, 8'h00, 1, 0, 1);
    cyc(1, 1, 8'h11, 1, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hC000, 16'hC000, 8'hEA, 0, 1, 1);
    // Async reset between jump phases
    cyc(1, 1, 8'h55, 1, 1, 1, 1, 0, 3'b000, 8'h00, 16'h0000, 16'hC000, 16'hC000, 8'h11, 1, 0, 1);
    cyc(0, 1, 8'h55, 1, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFC, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 1, 8'h78, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFC, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFD, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 1, 8'h9A, 0, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'hFFFD, 16'hFFFC, 8'hEA, 0, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h9A78, 16'h9A78, 8'hEA, 0, 0, 1);
    cyc(1, 1, 8'h00, 1, 0, 0, 0, 0, 3'b000, 8'h00, 16'h0000, 16'h9A78, 16'h9A78, 8'hEA, 0, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end stage directly upstream of the instruction decoder: owns the 16-bit program counter, drives the memory address bus, captures opcode bytes and presents them to the decoder.

- Applies the decoder's PC controls (`increment`, `lower_byte`, `pc_data`, `branch_uncon`, `branch_con`, `branch_op`).
- Runs the reset-vector fetch (FFFC/FFFD), then raises `normal`.
- Flushes the decoder with NOP on every taken branch or jump.

## Interface
Parameters:
- RESET_VECTOR, 16'hFFFC, address of the reset-vector low byte; the high byte is at RESET_VECTOR+1.
- NOP_OPCODE, 8'hEA, opcode injected on flush and held during reset.

Ports:
- clk_1  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- increment  in  1  PC <= PC+1 on this cycle's accepted read.
- lower_byte  in  1  jump load phase: 1 = stage `data_in` as target low byte; 0 = load {data_in, staged low} into PC.
- pc_data  in  1  address source: 1 = PC, 0 = `addr_in`.
- addr_in  in  16  operand/data address from the datapath.
- branch_uncon  in  1  unconditional jump load (uses `lower_byte` phasing).
- branch_con  in  1  conditional relative branch; offset = `data_in`.
- branch_op  in  3  [2:1] flag select (00 N, 01 V, 10 C, 11 Z); [0] required flag value.
- status  in  8  processor status, 6502 layout (N=7, V=6, Z=1, C=0).
- data_in  in  8  memory read data.
- mem_ready  in  1  memory has valid data this cycle; 0 = stall.
- address  out  16  memory address bus.
- pc  out  16  current program counter.
- instruction  out  8  opcode byte to the decoder.
- instr_valid  out  1  `instruction` was captured this cycle.
- flush  out  1  one-cycle pulse: decoder must discard its IR and load NOP.
- normal  out  1  1 once the reset vector is loaded; gates the decoder.

## Operation
- **FSM states:** VEC_LO, VEC_HI, RUN.
- **Reset (rst=0, asynchronous):**
  - state=VEC_LO, pc=RESET_VECTOR, staged_lo=0.
  - instruction=NOP_OPCODE; instr_valid=0, flush=0, normal=0.
  - address=RESET_VECTOR.
- **VEC_LO:** address=RESET_VECTOR. On mem_ready: staged_lo<=data_in, go to VEC_HI. Otherwise hold.
- **VEC_HI:** address=RESET_VECTOR+1. On mem_ready: pc<={data_in, staged_lo}, go to RUN.
- **RUN:**
  - normal=1.
  - address = pc_data ? pc : addr_in (combinational).
- **Accepted cycle** = RUN & mem_ready. With mem_ready=0, every register holds and instr_valid=0.
- **PC update priority** (accepted cycles only):
  1. branch_uncon & lower_byte: staged_lo<=data_in; pc<=pc+increment.
  2. branch_uncon & !lower_byte: pc<={data_in, staged_lo}; flush=1.
  3. branch_con & taken: pc<=pc+1+sext(data_in); flush=1.
  4. branch_con & not taken: pc<=pc+1.
  5. increment: pc<=pc+1.
  6. Otherwise pc holds.
- **Branch condition:** taken = (selected status flag == branch_op[0]).
- **PC arithmetic:** 16-bit modulo. FFFF+1 = 0000; 0005 + 1 + sext(8'hF0) = FFF6.
- **Instruction capture:** on accepted cycles with pc_data=1 and no flush, instruction<=data_in and instr_valid=1.
- **Flush cycle:** instruction<=NOP_OPCODE, instr_valid=0.
- **Reset mid-operation:** rst overrides everything immediately; any in-progress jump staging is discarded.

## Timing
- Combinational paths: `address`, and the branch condition feeding next-PC.
- Registered outputs: pc, instruction, instr_valid, flush, normal.
- Reset-to-RUN latency: 2 accepted cycles after rst rises. normal=1 from the cycle after the VEC_HI acceptance.
- Opcode latency: `instruction` is valid one edge after the accepted read.
- flush width: exactly one cycle. The redirected PC is on `address` in that same cycle.
- Stall: mem_ready=0 for N cycles delays every transition by N; no PC drift.
- Control conflicts: branch_uncon together with branch_con resolves by the priority list; branch_con is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - branch_op flag-select codes;
  - status bit indices;
  - RESET_VECTOR and NOP_OPCODE defaults;
  - FSM state encoding.
- Sub-module `branch_condition`: combinational (status, branch_op) -> taken. The decoder test bench reuses it.
- Expected size: ~180 lines of RTL.

## Test plan
- **Reset vector:** memory FFFC=34, FFFD=12, mem_ready=1. Required: address FFFC then FFFD; pc=1234 and normal=1 after 2 cycles; instruction=EA throughout.
- **Sequential fetch with stall:** memory at 1234..1236 holds A9, 05, EA; mem_ready low 3 cycles mid-stream. Required: pc advances only on ready cycles; instr_valid pulses once per captured byte.
- **Taken backward branch:** pc=0005, branch_con=1, branch_op=3'b111 (BEQ), Z=1, data_in=F0. Required: pc=FFF6, flush=1 for one cycle, instruction=EA.
- **Not-taken branch:** same stimulus with Z=0. Required: pc=0006, flush=0.
- **Jump:** lower_byte phase data_in=00, then high phase data_in=C0. Required: pc=C000, flush pulse; pc wraps FFFF->0000 on increment.
- **Async reset mid-jump:** rst=0 between the jump phases. Required: immediate pc=FFFC, normal=0, staged byte discarded.
